// File: rtl/alu_pkg.sv
// Shared definitions for the TotalALU front-end sequencer.
// Holds the ALU function codes, the sequencer state encoding and
// helpers that classify a request funct as single-cycle or multiply/divide.
package alu_pkg;

    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_NOP   = 6'd0;
    localparam logic [FUNCT_W-1:0] FUNCT_SRL   = 6'd2;
    localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'd16;
    localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'd18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'd25;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'd27;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 6'd32;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 6'd34;
    localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'd36;
    localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'd37;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'd42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MD_RUN,
        ST_GAP,
        ST_RD_HI,
        ST_RESP_HI,
        ST_RD_LO,
        ST_RESP
    } seq_state_t;

    // Ops the ALU completes combinationally in one cycle.
    function automatic logic is_single(input logic [FUNCT_W-1:0] funct);
        return (funct == FUNCT_AND) || (funct == FUNCT_OR)  ||
               (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
               (funct == FUNCT_SLT) || (funct == FUNCT_SRL);
    endfunction

    // Ops that run for several cycles and leave their result in HI/LO.
    function automatic logic is_md(input logic [FUNCT_W-1:0] funct);
        return (funct == FUNCT_MULTU) || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Loadable down-counter used to time the MD_RUN and GAP phases.
// Ports: clk, reset (async active-low), load/load_val (load has priority),
//        en (decrement, saturates at 0), done_c (count is zero).
module alu_seq_timer #(
    parameter int unsigned CW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          done_c
);

    logic [CW-1:0] count;

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for the TotalALU datapath.
// Accepts one op over req_valid/req_ready, drives alu_signal/alu_data_a/b,
// times MULTU/DIVU, issues MFHI/MFLO itself, and returns one beat (single
// cycle ops, illegal funct) or two beats HI then LO over resp_valid/resp_ready.
// Ports: clk, reset (async active-low), req_* request channel, resp_* response
//        channel, alu_signal/alu_data_a/alu_data_b to the ALU, alu_out from it.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned MD_GAP    = 2,
    parameter int unsigned W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FUNCT_W-1:0] req_funct,
    input  logic [W-1:0]       req_a,
    input  logic [W-1:0]       req_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [W-1:0]       resp_data,
    output logic               resp_last,
    output logic               resp_err,
    output logic [FUNCT_W-1:0] alu_signal,
    output logic [W-1:0]       alu_data_a,
    output logic [W-1:0]       alu_data_b,
    input  logic [W-1:0]       alu_out
);

    localparam int unsigned CNT_MAX = (MD_CYCLES > MD_GAP) ? MD_CYCLES : MD_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_t         state;
    logic [FUNCT_W-1:0] funct_q;
    // alu_signal is registered, so a capture state spends one cycle letting
    // the ALU see its code and captures alu_out on the following edge.
    logic               armed;

    logic               accept_c;
    logic               tmr_load_c;
    logic [CNT_W-1:0]   tmr_val_c;
    logic               tmr_en_c;
    logic               tmr_done_c;

    assign accept_c = req_valid && req_ready;

    // Timer control: load on MD acceptance and again when MD_RUN expires.
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = CNT_W'(MD_CYCLES - 1);
        tmr_en_c   = (state == ST_MD_RUN) || (state == ST_GAP);
        if (state == ST_IDLE) begin
            tmr_load_c = accept_c && is_md(req_funct);
        end else if ((state == ST_MD_RUN) && tmr_done_c) begin
            tmr_load_c = 1'b1;
            tmr_val_c  = CNT_W'(MD_GAP - 1);
        end
    end

    alu_seq_timer #(.CW(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .en       (tmr_en_c),
        .done_c   (tmr_done_c)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            funct_q    <= FUNCT_NOP;
            armed      <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_last  <= 1'b0;
            resp_err   <= 1'b0;
            alu_signal <= FUNCT_NOP;
            alu_data_a <= '0;
            alu_data_b <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    alu_signal <= FUNCT_NOP;
                    armed      <= 1'b0;
                    req_ready  <= 1'b1;
                    if (accept_c) begin
                        req_ready <= 1'b0;
                        funct_q   <= req_funct;
                        if (is_single(req_funct) || is_md(req_funct)) begin
                            alu_data_a <= req_a;
                            alu_data_b <= req_b;
                            state      <= is_md(req_funct) ? ST_MD_RUN : ST_EXEC;
                        end else begin
                            // Illegal funct: answer at once, ALU left idle.
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_last  <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    alu_signal <= funct_q;
                    armed      <= ~armed;
                    if (armed) begin
                        resp_valid <= 1'b1;
                        resp_data  <= alu_out;
                        resp_last  <= 1'b1;
                        resp_err   <= 1'b0;
                        state      <= ST_RESP;
                    end
                end
                ST_MD_RUN: begin
                    alu_signal <= funct_q;
                    if (tmr_done_c) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    alu_signal <= funct_q;
                    if (tmr_done_c) begin
                        state <= ST_RD_HI;
                    end
                end
                ST_RD_HI: begin
                    alu_signal <= FUNCT_MFHI;
                    armed      <= ~armed;
                    if (armed) begin
                        resp_valid <= 1'b1;
                        resp_data  <= alu_out;
                        resp_last  <= 1'b0;
                        resp_err   <= 1'b0;
                        state      <= ST_RESP_HI;
                    end
                end
                ST_RESP_HI: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_RD_LO;
                    end
                end
                ST_RD_LO: begin
                    alu_signal <= FUNCT_MFLO;
                    armed      <= ~armed;
                    if (armed) begin
                        resp_valid <= 1'b1;
                        resp_data  <= alu_out;
                        resp_last  <= 1'b1;
                        resp_err   <= 1'b0;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // alu_signal holds so HI/LO are left undisturbed while stalled.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                        resp_last  <= 1'b0;
                        resp_err   <= 1'b0;
                        alu_data_a <= '0;
                        alu_data_b <= '0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural TotalALU model.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int unsigned W = 32;
    localparam int MD_LAT = 32 + 2 + 2;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   req_funct;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_last;
    logic         resp_err;
    logic [5:0]   alu_signal;
    logic [W-1:0] alu_data_a;
    logic [W-1:0] alu_data_b;
    logic [W-1:0] alu_out;

    int n_tests = 0;
    int n_fail  = 0;

    alu_sequencer #(.MD_CYCLES(32), .MD_GAP(2), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct  (req_funct),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .resp_err   (resp_err),
        .alu_signal (alu_signal),
        .alu_data_a (alu_data_a),
        .alu_data_b (alu_data_b),
        .alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural TotalALU: combinational ops plus HI/LO written by MULTU/DIVU.
    logic [W-1:0] hi, lo;
    always_ff @(posedge clk) begin
        if (alu_signal == 6'd25) begin
            {hi, lo} <= alu_data_a * alu_data_b;
        end else if (alu_signal == 6'd27 && alu_data_b != 0) begin
            hi <= alu_data_a % alu_data_b;
            lo <= alu_data_a / alu_data_b;
        end
    end

    always_comb begin
        case (alu_signal)
            6'd36:   alu_out = alu_data_a & alu_data_b;
            6'd37:   alu_out = alu_data_a | alu_data_b;
            6'd32:   alu_out = alu_data_a + alu_data_b;
            6'd34:   alu_out = alu_data_a - alu_data_b;
            6'd42:   alu_out = ($signed(alu_data_a) < $signed(alu_data_b)) ? 32'd1 : 32'd0;
            6'd2:    alu_out = alu_data_a >> alu_data_b[4:0];
            6'd16:   alu_out = hi;
            6'd18:   alu_out = lo;
            default: alu_out = '0;
        endcase
    end

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        bit           md;
        bit           err;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op, check its beats, latency and ALU code sequence.
    task automatic run_op(input vec_t v, input int stall);
        int k;
        int n_code;
        int n_nz;
        req_funct = v.funct;
        req_a     = v.a;
        req_b     = v.b;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_ready_after_accept", 32'(req_ready), 32'd0);

        k = 0; n_code = 0; n_nz = 0;
        while (!resp_valid && k < 100) begin
            @(posedge clk); #1; k++;
            if (alu_signal == v.funct) n_code++;
            if (alu_signal != 0) n_nz++;
        end
        chk("first_beat_latency", 32'(k), v.err ? 32'd0 : (v.md ? 32'(MD_LAT) : 32'd2));
        chk("first_beat_data", resp_data, v.md ? v.exp_hi : v.exp_lo);
        chk("first_beat_last", 32'(resp_last), v.md ? 32'd0 : 32'd1);
        chk("first_beat_err", 32'(resp_err), v.err ? 32'd1 : 32'd0);
        if (v.err) chk("err_alu_idle", 32'(n_nz), 32'd0);

        if (v.md) begin
            chk("md_code_cycles", 32'(n_code), 32'd34);
            chk("md_hi_code", 32'(alu_signal), 32'd16);
            if (stall > 0) begin
                resp_ready = 1'b0;
                repeat (stall) begin
                    req_valid = 1'b1;
                    req_funct = 6'd32;
                    @(posedge clk); #1;
                    chk("stall_hi_valid", 32'(resp_valid), 32'd1);
                    chk("stall_hi_data", resp_data, v.exp_hi);
                    chk("stall_req_ready", 32'(req_ready), 32'd0);
                end
                req_valid  = 1'b0;
                resp_ready = 1'b1;
            end
            @(posedge clk); #1;
            k = 0;
            while (!resp_valid && k < 100) begin
                @(posedge clk); #1; k++;
            end
            chk("lo_latency", 32'(k), 32'd2);
            chk("lo_data", resp_data, v.exp_lo);
            chk("lo_last", 32'(resp_last), 32'd1);
            chk("lo_code", 32'(alu_signal), 32'd18);
        end

        @(posedge clk); #1;
        chk("done_resp_valid", 32'(resp_valid), 32'd0);
        chk("done_req_ready", 32'(req_ready), 32'd1);
        if (stall > 0) begin
            // Requests seen while busy must not have been queued.
            n_nz = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (resp_valid || alu_signal != 0) n_nz++;
            end
            chk("no_queued_op", 32'(n_nz), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        vec_t v;
        vecs[0]  = '{6'd32, 32'd5,          32'd7,          32'd0, 32'd12,         1'b0, 1'b0};
        vecs[1]  = '{6'd34, 32'd3,          32'd5,          32'd0, 32'hFFFF_FFFE,  1'b0, 1'b0};
        vecs[2]  = '{6'd42, 32'd3,          32'd5,          32'd0, 32'd1,          1'b0, 1'b0};
        vecs[3]  = '{6'd42, 32'd5,          32'd3,          32'd0, 32'd0,          1'b0, 1'b0};
        vecs[4]  = '{6'd42, 32'hFFFF_FFFF,  32'd1,          32'd0, 32'd1,          1'b0, 1'b0};
        vecs[5]  = '{6'd2,  32'd16,         32'd2,          32'd0, 32'd4,          1'b0, 1'b0};
        vecs[6]  = '{6'd36, 32'h0000_F0F0,  32'h0000_FF00,  32'd0, 32'h0000_F000,  1'b0, 1'b0};
        vecs[7]  = '{6'd37, 32'h0000_00F0,  32'h0000_000F,  32'd0, 32'h0000_00FF,  1'b0, 1'b0};
        vecs[8]  = '{6'd27, 32'd100,        32'd7,          32'd2, 32'd14,         1'b1, 1'b0};
        vecs[9]  = '{6'd25, 32'h0001_0000,  32'h0003_0000,  32'd3, 32'd0,          1'b1, 1'b0};
        vecs[10] = '{6'd63, 32'd9,          32'd9,          32'd0, 32'd0,          1'b0, 1'b1};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_funct  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_alu_signal", 32'(alu_signal), 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        chk("idle_alu_signal", 32'(alu_signal), 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], 0);
        end

        // DIVU with HI beat stalled for 10 cycles and requests poked meanwhile.
        run_op(vecs[8], 10);

        // Reset in the middle of MD_RUN.
        req_funct = 6'd27; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("mid_md_code", 32'(alu_signal), 32'd27);
        reset = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_alu_signal", 32'(alu_signal), 32'd0);
        chk("abort_data_a", alu_data_a, 32'd0);
        chk("abort_data_b", alu_data_b, 32'd0);
        chk("abort_resp_flags", {30'd0, resp_last, resp_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        bad = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (resp_valid || alu_signal != 0 || !req_ready) bad++;
        end
        chk("abort_no_beats", 32'(bad), 32'd0);

        v = '{6'd32, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, 1'b0};
        run_op(v, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
